f1_start_sequencer: RTL and testbench
=====================================

Name: f1_start_sequencer

Overview:
- Controller that drives the F1 start-light stage and times the driver's reaction.
- Generates the one-cycle `en` pulses that step the 8-bit light pattern 00→01→03→…→FF.
- Once all lights are lit, holds for a pseudo-random delay, then issues one more step so the light stage wraps FF→00 (lights out).
- Measures milliseconds from lights out to the react button; detects false starts.

Parameters:
- TICK_DIV, 1000: clk cycles per ms tick (≥2).
- STEP_MS, 500: ms between light steps (≥1).
- MIN_HOLD_MS, 200: fixed part of hold delay in ms (≥1).
- RT_W, 16: width of the reaction-time counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin sequence; sampled only in IDLE.
- react  in  1  driver button, already synchronised to clk; level.
- lights  in  8  current pattern from the light stage `data_out`.
- step_en  out  1  one-cycle pulse to the light stage `en`; registered.
- busy  out  1  high when state ≠ IDLE.
- rt_ms  out  RT_W  last reaction time in ms; held until next result.
- rt_valid  out  1  one-cycle pulse when rt_ms is updated.
- false_start  out  1  sticky flag; cleared on accepted start.
- lfsr_q  out  7  LFSR value (debug/verification).

Behaviour:
- Reset values: step_en=0, busy=0, rt_ms=0, rt_valid=0, false_start=0, lfsr_q=7'h01, react_q=0, state IDLE. Reset mid-operation returns to these immediately. The light stage is reset by the same rst.
- LFSR: 7-bit Fibonacci, shift left, feedback q[6]^q[5]. Advances every clk in every state. Never zero.
- Rising-edge detect: react_rise = react & ~react_q.
- Prescaler: cleared to 0 on every state entry. ms_tick is asserted when it equals TICK_DIV-1, then it wraps to 0. It runs in all non-IDLE states.
- IDLE:
  - start=1 → FILL; false_start cleared.
  - react is ignored.
- FILL, entered at cycle S:
  - Step counter counts ms_ticks. Every STEP_MS ticks, step_en is high one cycle.
  - First pulse at S+STEP_MS*TICK_DIV, then every STEP_MS*TICK_DIV cycles.
  - If lights==8'hFF is observed → HOLD, capturing H = MIN_HOLD_MS + lfsr_q (range MIN_HOLD_MS+1 .. MIN_HOLD_MS+127).
  - No step_en is issued in the transition cycle.
  - If lights==FF already at start, HOLD is entered on the first FILL cycle.
- HOLD, entered at cycle T:
  - hold_cnt decrements on each ms_tick.
  - On the H-th tick → REACT; step_en is high at cycle T+H*TICK_DIV (drives lights FF→00).
- REACT:
  - rt counter starts at 0 and increments on each ms_tick, saturating at 2^RT_W-1.
  - react_rise → rt_ms=count, rt_valid=1 for one cycle, then IDLE.
  - Timeout: when the count reaches all-ones, rt_ms=all-ones, rt_valid pulses, then IDLE.
- False start: react_rise while in FILL or HOLD → false_start=1, IDLE, no further step_en. The light stage keeps its partial pattern until the next sequence.
- Simultaneous events:
  - False start has priority over the HOLD→REACT step and over the FILL→HOLD transition.
  - In REACT, a react_rise in the same cycle as saturation reports the saturated value once.
- start while busy is ignored. A button held high before start causes no false start (edge-only).
- Width rule: hold_cnt width = $clog2(MIN_HOLD_MS+128). All counters are unsigned, with no wrap except the prescaler and step counter.

Decomposition:
- Package f1_pkg holds:
  - state enum typedef {IDLE, FILL, HOLD, REACT};
  - LFSR_W=7 and LFSR_SEED=7'h01;
  - LIGHTS_ALL=8'hFF and LIGHTS_OFF=8'h00.
- Sub-module f1_lfsr7: clk, rst, q[6:0], free-running, reused by later blocks.
- Prescaler, counters and FSM stay in the top module.

Test Plan (TICK_DIV=4, STEP_MS=2, MIN_HOLD_MS=3, RT_W=6, real light stage attached):
1. Reset, start pulse at cycle S → step_en at S+8, S+16, …, S+64. Lights 01,03,07,…,FF after 8 pulses. HOLD is entered and busy=1 throughout.
2. Record lfsr_q=L at HOLD entry T → single step_en at T+(3+L)*4. Lights go to 00 and the state is REACT.
3. Raise react 20 cycles after REACT entry (5 ticks) → rt_valid for exactly one cycle, rt_ms=5, busy=0.
4. Raise react after 3 steps in FILL → false_start=1, busy=0, no further step_en, lights stay 07. A new start clears false_start.
5. No react in REACT → after 63*4 cycles rt_valid pulses with rt_ms=63, then IDLE.
6. Three cases:
   - assert rst mid-HOLD → all outputs at reset values in the same cycle;
   - start pulses while busy → no effect;
   - react held high from before start → no false start.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 start-light controller.
// States, LFSR seed and light patterns live here.
package f1_pkg;
  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD,
    REACT
  } state_e;

  localparam int LFSR_W = 7;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 7'h01;

  localparam logic [7:0] LIGHTS_ALL = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF = 8'h00;
endpackage

// File: rtl/f1_start_sequencer_if.sv
// Bundle between the start sequencer, the light stage and the driver.
// slave is the sequencer side, master is the environment side.
interface f1_start_sequencer_if
  import f1_pkg::*;
#(
  parameter int RT_W = 16
);
  logic              start;
  logic              react;
  logic [7:0]        lights;
  logic              step_en;
  logic              busy;
  logic [RT_W-1:0]   rt_ms;
  logic              rt_valid;
  logic              false_start;
  logic [LFSR_W-1:0] lfsr_q;

  modport master (
    output start, react, lights,
    input  step_en, busy, rt_ms, rt_valid,
    input  false_start, lfsr_q
  );

  modport slave (
    input  start, react, lights,
    output step_en, busy, rt_ms, rt_valid,
    output false_start, lfsr_q
  );
endinterface

// File: rtl/f1_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR, taps 7 and 6.
// Maximal length, so the all-zero state is never reached.
module f1_lfsr7
  import f1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[LFSR_W-2:0], q[6] ^ q[5]};
    end
  end
endmodule

// File: rtl/f1_start_sequencer.sv
// Steps the start lights, holds a random time, turns them out
// and measures the driver's reaction time in ms.
module f1_start_sequencer
  import f1_pkg::*;
#(
  parameter int TICK_DIV    = 1000,
  parameter int STEP_MS     = 500,
  parameter int MIN_HOLD_MS = 200,
  parameter int RT_W        = 16
)(
  input  logic clk,
  input  logic rst,
  f1_start_sequencer_if.slave io
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STEP_MS + 1);
  localparam int HW = $clog2(MIN_HOLD_MS + 128);

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(STEP_MS - 1);
  localparam logic [HW-1:0] HOLD_BASE = HW'(MIN_HOLD_MS);
  localparam logic [RT_W-1:0] RT_MAX  = '1;
  localparam logic [RT_W-1:0] RT_PRE  =
    {{(RT_W-1){1'b1}}, 1'b0};

  state_e state_q, state_d;

  logic [PW-1:0]     presc_q, presc_d;
  logic [SW-1:0]     step_cnt_q, step_cnt_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [RT_W-1:0]   rt_cnt_q, rt_cnt_d;
  logic [RT_W-1:0]   rt_ms_q, rt_ms_d;
  logic              step_en_q, step_en_d;
  logic              rt_valid_q, rt_valid_d;
  logic              fs_q, fs_d;
  logic              react_q;
  logic [LFSR_W-1:0] lfsr;

  logic react_rise;
  logic ms_tick;
  logic lights_full;
  logic rt_sat;

  f1_lfsr7 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign react_rise  = io.react & ~react_q;
  assign ms_tick     = (state_q != IDLE) &&
                       (presc_q == PRESC_MAX);
  assign lights_full = (io.lights == LIGHTS_ALL);
  assign rt_sat      = ms_tick && (rt_cnt_q == RT_PRE);

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    rt_cnt_d   = rt_cnt_q;
    rt_ms_d    = rt_ms_q;
    step_en_d  = 1'b0;
    rt_valid_d = 1'b0;
    fs_d       = fs_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          state_d    = FILL;
          fs_d       = 1'b0;
          step_cnt_d = '0;
        end
      end
      FILL: begin
        // a false start outranks both stepping and the hold entry
        if (react_rise) begin
          fs_d    = 1'b1;
          state_d = IDLE;
        end else if (lights_full) begin
          state_d    = HOLD;
          hold_cnt_d = HOLD_BASE + HW'(lfsr);
        end else if (ms_tick) begin
          if (step_cnt_q == STEP_MAX) begin
            step_cnt_d = '0;
            step_en_d  = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q + SW'(1);
          end
        end
      end
      HOLD: begin
        if (react_rise) begin
          fs_d    = 1'b1;
          state_d = IDLE;
        end else if (ms_tick) begin
          if (hold_cnt_q == HW'(1)) begin
            step_en_d = 1'b1;
            state_d   = REACT;
            rt_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q - HW'(1);
          end
        end
      end
      REACT: begin
        if (rt_sat || react_rise) begin
          rt_ms_d    = rt_sat ? RT_MAX : rt_cnt_q;
          rt_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (ms_tick) begin
          rt_cnt_d = rt_cnt_q + RT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // the ms grid restarts on every state entry
    if ((state_d != state_q) || (state_q == IDLE) ||
        ms_tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      rt_cnt_q   <= '0;
      rt_ms_q    <= '0;
      step_en_q  <= 1'b0;
      rt_valid_q <= 1'b0;
      fs_q       <= 1'b0;
      react_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rt_cnt_q   <= rt_cnt_d;
      rt_ms_q    <= rt_ms_d;
      step_en_q  <= step_en_d;
      rt_valid_q <= rt_valid_d;
      fs_q       <= fs_d;
      react_q    <= io.react;
    end
  end

  assign io.step_en     = step_en_q;
  assign io.busy        = (state_q != IDLE);
  assign io.rt_ms       = rt_ms_q;
  assign io.rt_valid    = rt_valid_q;
  assign io.false_start = fs_q;
  assign io.lfsr_q      = lfsr;
endmodule

// File: tb/tb_f1_start_sequencer.sv
// Bench for f1_start_sequencer with a behavioural light stage and
// a cycle-offset reference model for steps, hold and reaction time.
module tb_f1_start_sequencer;
  import f1_pkg::*;

  localparam int TD = 4;
  localparam int SM = 2;
  localparam int MH = 3;
  localparam int RW = 6;
  localparam int RTMAX = (1 << RW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  int lit_n = 0;
  int prev_rt = 0;
  logic [6:0] l_cap;
  logic [6:0] lfsr_m;

  f1_start_sequencer_if #(.RT_W(RW)) bus ();

  f1_start_sequencer #(
    .TICK_DIV    (TD),
    .STEP_MS     (SM),
    .MIN_HOLD_MS (MH),
    .RT_W        (RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.lights <= LIGHTS_OFF;
    end else if (bus.step_en) begin
      bus.lights <= (bus.lights == LIGHTS_ALL) ?
        LIGHTS_OFF : {bus.lights[6:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 7'h01;
    else lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
  end

  function automatic logic [7:0] mask(input int n);
    return 8'((1 << n) - 1);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk();
    chk("rst_step_en", bus.step_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rt_ms", bus.rt_ms, 0);
    chk("rst_rt_valid", bus.rt_valid, 0);
    chk("rst_false_start", bus.false_start, 0);
    chk("rst_lfsr", bus.lfsr_q, 7'h01);
    chk("rst_lights", bus.lights, LIGHTS_OFF);
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 3);
    repeat (n) begin
      step();
      chk("idle_busy", bus.busy, 0);
    end
  endtask

  task automatic fs_tail(input logic [7:0] lw);
    step();
    bus.start = 1'b0;
    chk("fs_busy", bus.busy, 0);
    chk("fs_flag", bus.false_start, 1);
    chk("fs_step", bus.step_en, 0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("fs_no_step", bus.step_en, 0);
      chk("fs_lights", bus.lights, lw);
      chk("fs_idle", bus.busy, 0);
      chk("fs_sticky", bus.false_start, 1);
    end
    bus.react = 1'b0;
    step();
  endtask

  // fs_sel: -1 none, -2 at the cycle FF is seen, else cycle offset
  task automatic run_fill(input int fs_sel);
    int n0, need, last, fs_at, stop, npl;
    n0 = lit_n;
    need = 8 - n0;
    last = (need == 0) ? 0 : SM * TD * need + 1;
    fs_at = (fs_sel == -2) ? last : fs_sel;
    if (fs_at > last) fs_at = -1;
    stop = (fs_at >= 0) ? fs_at : last;
    for (int c = 0; c <= stop; c++) begin
      step();
      if (c == fs_at) bus.react = 1'b1;
      npl = (c == 0) ? 0 : (c - 1) / (SM * TD);
      if (npl > need) npl = need;
      chk("fill_lights", bus.lights, mask(n0 + npl));
      chk("fill_step", bus.step_en,
          (c > 0 && c % (SM * TD) == 0 &&
           c / (SM * TD) <= need));
      chk("fill_busy", bus.busy, 1);
      chk("fill_fs_clr", bus.false_start, 0);
      chk("fill_lfsr", bus.lfsr_q, lfsr_m);
      bus.start = 1'($urandom_range(0, 1));
    end
    if (fs_at >= 0) begin
      npl = fs_at / (SM * TD);
      lit_n = n0 + ((npl < need) ? npl : need);
      fs_tail(mask(lit_n));
    end else begin
      l_cap = lfsr_m;
      lit_n = 8;
    end
  endtask

  // fs_sel: -1 none, -2 on the final tick cycle, else random
  task automatic run_hold(input int fs_sel);
    int e, fs_at, stop;
    e = (MH + int'(l_cap)) * TD;
    fs_at = (fs_sel == -2) ? e - 1 :
            (fs_sel >= 0) ? fs_sel % e : -1;
    stop = (fs_at >= 0) ? fs_at : e;
    for (int c = 0; c <= stop; c++) begin
      step();
      if (c == fs_at) bus.react = 1'b1;
      chk("hold_step", bus.step_en, (c == e));
      chk("hold_busy", bus.busy, 1);
      chk("hold_lights", bus.lights, LIGHTS_ALL);
      chk("hold_lfsr", bus.lfsr_q, lfsr_m);
      if (c == 0) chk("hold_rt_ms", bus.rt_ms, prev_rt);
      bus.start = 1'($urandom_range(0, 1));
    end
    if (fs_at >= 0) fs_tail(LIGHTS_ALL);
  endtask

  // d: cycles after lights out at which react rises
  task automatic react_phase(input int d);
    int vc, er;
    bus.react = 1'b0;
    vc = ((d < RTMAX * TD - 1) ? d : RTMAX * TD - 1) + 1;
    er = (vc / TD >= RTMAX) ? RTMAX : d / TD;
    for (int c = 1; c <= vc; c++) begin
      step();
      if (c == d) bus.react = 1'b1;
      if (c == vc) bus.start = 1'b0;
      else bus.start = 1'($urandom_range(0, 1));
      if (c == 1) chk("out_lights", bus.lights, LIGHTS_OFF);
      chk("rt_valid", bus.rt_valid, (c == vc));
      chk("rt_busy", bus.busy, (c < vc));
      chk("rt_ms", bus.rt_ms, (c == vc) ? er : prev_rt);
    end
    prev_rt = er;
    lit_n = 0;
    step();
    chk("rt_valid_once", bus.rt_valid, 0);
    chk("rt_ms_held", bus.rt_ms, er);
    chk("rt_idle", bus.busy, 0);
    bus.react = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.react = 1'b0;
    repeat (3) step();
    reset_chk();
    @(negedge clk);
    rst = 1'b0;
    step();

    gap(); bus.start = 1'b1;
    run_fill(-1); run_hold(-1); react_phase(20);

    gap(); bus.start = 1'b1;
    run_fill(3 * SM * TD + 1 + $urandom_range(0, 6));
    chk("fs_partial", bus.lights, 8'h07);
    gap(); bus.start = 1'b1;
    run_fill(-1); run_hold(-1); react_phase(100000);

    gap(); bus.start = 1'b1;
    run_fill(-1); run_hold($urandom_range(0, 1000));
    gap(); bus.start = 1'b1;
    run_fill(-1); run_hold(-2);
    gap(); bus.start = 1'b1;
    run_fill(-1); run_hold(-1);
    react_phase($urandom_range(1, 260));

    gap(); bus.start = 1'b1;
    run_fill(-2);
    gap(); bus.start = 1'b1;
    run_fill(-1); run_hold(-1);
    react_phase(RTMAX * TD - 1);

    bus.react = 1'b1;
    gap(); bus.start = 1'b1;
    run_fill(-1); run_hold(-1);
    react_phase($urandom_range(1, 200));

    gap(); bus.start = 1'b1;
    run_fill(-1);
    repeat (5) step();
    chk("pre_rst_busy", bus.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    reset_chk();
    bus.start = 1'b0;
    lit_n = 0;
    prev_rt = 0;
    @(negedge clk);
    rst = 1'b0;
    step();

    gap(); bus.start = 1'b1;
    run_fill(-1); run_hold(-1);
    react_phase($urandom_range(1, 250));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
